// File: rtl/score_pkg.sv
// Shared definitions for the score BCD converter: digit width, default
// sizing, FSM state encoding and the leading-zero blank reset mask.
package score_pkg;

  localparam int BCD_W      = 4;
  localparam int DEF_DIGITS = 6;
  localparam int DEF_BIN_W  = 20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Blank mask shown after reset: every digit dark except the ones digit,
  // so a zero score displays as a single "0".
  localparam logic [DEF_DIGITS-1:0] BLANK_RST_DEFAULT = {{(DEF_DIGITS-1){1'b1}}, 1'b0};

endpackage

// File: rtl/score_bcd_converter_add3.sv
// One double-dabble correction cell: a BCD nibble of 5 or more gets +3
// before the shift so that it carries correctly into the next digit.
module bcd_add3
  import score_pkg::*;
(
  input  logic [BCD_W-1:0] i_nibble,
  output logic [BCD_W-1:0] o_nibble
);

  logic [BCD_W-1:0] w_sum;

  assign w_sum    = i_nibble + 4'd3;
  assign o_nibble = (i_nibble >= 4'd5) ? w_sum : i_nibble;

endmodule

// File: rtl/score_bcd_converter.sv
// Sequential binary-to-BCD converter feeding the seven-segment decoders.
// A start pulse loads the value (saturated to the largest displayable
// number), BIN_W shift-add-3 cycles build the digits, and a final cycle
// publishes digits, the leading-zero blank mask and the overflow flag.
module score_bcd_converter
  import score_pkg::*;
#(
  parameter int BIN_W  = DEF_BIN_W,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic [BIN_W-1:0]        i_bin_in,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [BCD_W*DIGITS-1:0] o_digits,
  output logic [DIGITS-1:0]       o_blank,
  output logic                    o_overflow
);

  localparam int                SCR_W     = BCD_W * DIGITS;
  localparam int                CNT_W     = $clog2(BIN_W + 1);
  localparam logic [63:0]       MAX_VAL   = 64'(10 ** DIGITS) - 64'd1;
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  state_t                   r_state;
  logic [BIN_W-1:0]         r_bin;
  logic [SCR_W-1:0]         r_scratch;
  logic [CNT_W-1:0]         r_count;
  logic                     r_pend_ovf;
  logic                     r_busy;
  logic                     r_done;
  logic [SCR_W-1:0]         r_digits;
  logic [DIGITS-1:0]        r_blank;
  logic                     r_overflow;

  logic [SCR_W-1:0]         w_adj;
  logic [SCR_W+BIN_W-1:0]   w_shifted;
  logic [DIGITS-1:0]        w_blank;
  logic                     w_higher_zero;

  // One add-3 correction cell per digit of the scratch register.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_nibble (r_scratch[g*BCD_W +: BCD_W]),
      .o_nibble (w_adj[g*BCD_W +: BCD_W])
    );
  end

  // The top scratch bit falls off the end; saturation keeps it zero.
  assign w_shifted = {w_adj, r_bin} << 1;

  // A digit is blanked only when it and every digit above it are zero;
  // the ones digit always shows.
  always_comb begin
    w_blank       = '0;
    w_higher_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_higher_zero = w_higher_zero && (r_scratch[i*BCD_W +: BCD_W] == '0);
      w_blank[i]    = w_higher_zero;
    end
  end

  // Conversion FSM with registered busy/done and result outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_bin      <= '0;
      r_scratch  <= '0;
      r_count    <= '0;
      r_pend_ovf <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_digits   <= '0;
      r_blank    <= BLANK_RST;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            if (64'(i_bin_in) > MAX_VAL) begin
              r_bin      <= BIN_W'(MAX_VAL);
              r_pend_ovf <= 1'b1;
            end else begin
              r_bin      <= i_bin_in;
              r_pend_ovf <= 1'b0;
            end
            r_scratch <= '0;
            r_count   <= CNT_W'(BIN_W);
            r_busy    <= 1'b1;
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          r_scratch <= w_shifted[SCR_W+BIN_W-1:BIN_W];
          r_bin     <= w_shifted[BIN_W-1:0];
          r_count   <= r_count - CNT_W'(1);
          if (r_count == CNT_W'(1)) begin
            r_state <= FINISH;
          end
        end
        FINISH: begin
          r_digits   <= r_scratch;
          r_blank    <= w_blank;
          r_overflow <= r_pend_ovf;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_digits   = r_digits;
  assign o_blank    = r_blank;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_score_bcd_converter.sv
// Directed bench for score_bcd_converter: each scenario task drives its
// stimulus and compares outputs against hand-computed BCD values.
module tb_score_bcd_converter;

  localparam int BIN_W  = 20;
  localparam int DIGITS = 6;

  logic                clk;
  logic                reset;
  logic                start;
  logic [BIN_W-1:0]    bin_in;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] digits;
  logic [DIGITS-1:0]   blank;
  logic                overflow;

  int checks;
  int failures;

  score_bcd_converter #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_start    (start),
    .i_bin_in   (bin_in),
    .o_busy     (busy),
    .o_done     (done),
    .o_digits   (digits),
    .o_blank    (blank),
    .o_overflow (overflow)
  );

  // 100 MHz-style free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one cycle; returns 1 ns after the sampling edge.
  task automatic do_start(input logic [BIN_W-1:0] value);
    @(negedge clk);
    start  = 1'b1;
    bin_in = value;
    @(posedge clk);
    #1;
    start  = 1'b0;
  endtask

  // Step edges until done is seen (bounded); reports latency and busy cycles.
  task automatic wait_done(output int cycles, output int busy_cycles, output bit seen);
    cycles      = 0;
    busy_cycles = (busy === 1'b1) ? 1 : 0;
    seen        = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(posedge clk);
      #1;
      cycles++;
      if (done === 1'b1) seen = 1'b1;
      else if (busy === 1'b1) busy_cycles++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    bin_in = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags: busy=%b done=%b ovf=%b expected 0 0 0", busy, done, overflow);
    end
    checks++;
    if (digits !== 24'h000000 || blank !== 6'b111110) begin
      failures++;
      $display("[TB] FAIL reset_result: digits=%h blank=%b expected 000000 111110", digits, blank);
    end
  endtask

  task automatic test_zero();
    int cyc, bcyc;
    bit seen;
    do_start(20'd0);
    wait_done(cyc, bcyc, seen);
    checks++;
    if (!seen || cyc != 21) begin
      failures++;
      $display("[TB] FAIL zero_latency: seen=%b cycles=%0d expected 1 21", seen, cyc);
    end
    checks++;
    if (digits !== 24'h000000 || blank !== 6'b111110 || overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL zero_result: digits=%h blank=%b ovf=%b expected 000000 111110 0", digits, blank, overflow);
    end
  endtask

  task automatic test_full_digits();
    int cyc, bcyc;
    bit seen;
    do_start(20'd123456);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (digits !== 24'h000000 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_conversion: digits=%h busy=%b expected 000000 1", digits, busy);
    end
    wait_done(cyc, bcyc, seen);
    bcyc += 10;
    checks++;
    if (!seen || bcyc != 21) begin
      failures++;
      $display("[TB] FAIL busy_length: seen=%b busy_cycles=%0d expected 1 21", seen, bcyc);
    end
    checks++;
    if (digits !== 24'h123456 || blank !== 6'b000000 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL conv_123456: digits=%h blank=%b busy=%b expected 123456 000000 0", digits, blank, busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL done_single_pulse: done=%b expected 0", done);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bcyc;
    bit seen;
    do_start(20'd1000);
    wait_done(cyc, bcyc, seen);
    checks++;
    if (!seen || digits !== 24'h001000 || blank !== 6'b110000) begin
      failures++;
      $display("[TB] FAIL conv_1000: seen=%b digits=%h blank=%b expected 1 001000 110000", seen, digits, blank);
    end
    // Next start lands while done is still high.
    do_start(20'd7);
    wait_done(cyc, bcyc, seen);
    checks++;
    if (!seen || cyc != 21 || digits !== 24'h000007 || blank !== 6'b111110) begin
      failures++;
      $display("[TB] FAIL conv_7: seen=%b cycles=%0d digits=%h blank=%b expected 1 21 000007 111110", seen, cyc, digits, blank);
    end
  endtask

  task automatic test_overflow();
    int cyc, bcyc;
    bit seen;
    do_start(20'hFFFFF);
    wait_done(cyc, bcyc, seen);
    checks++;
    if (!seen || digits !== 24'h999999 || overflow !== 1'b1 || blank !== 6'b000000) begin
      failures++;
      $display("[TB] FAIL conv_saturate: seen=%b digits=%h ovf=%b blank=%b expected 1 999999 1 000000", seen, digits, overflow, blank);
    end
    do_start(20'd5);
    wait_done(cyc, bcyc, seen);
    checks++;
    if (!seen || digits !== 24'h000005 || overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL conv_after_ovf: seen=%b digits=%h ovf=%b expected 1 000005 0", seen, digits, overflow);
    end
  endtask

  task automatic test_start_while_busy();
    int cyc, bcyc;
    bit seen;
    int extra;
    do_start(20'd42);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start  = 1'b1;
    bin_in = 20'd99;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(cyc, bcyc, seen);
    checks++;
    if (!seen || digits !== 24'h000042 || blank !== 6'b111100) begin
      failures++;
      $display("[TB] FAIL busy_ignore: seen=%b digits=%h blank=%b expected 1 000042 111100", seen, digits, blank);
    end
    extra = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra != 0 || digits !== 24'h000042) begin
      failures++;
      $display("[TB] FAIL busy_no_queue: extra_activity=%0d digits=%h expected 0 000042", extra, digits);
    end
  endtask

  task automatic test_reset_abort();
    int cyc, bcyc;
    bit seen;
    int extra;
    do_start(20'd500000);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || digits !== 24'h000000 || blank !== 6'b111110) begin
      failures++;
      $display("[TB] FAIL abort_state: busy=%b done=%b digits=%h blank=%b expected 0 0 000000 111110", busy, done, digits, blank);
    end
    extra = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("[TB] FAIL abort_no_done: extra_activity=%0d expected 0", extra);
    end
    do_start(20'd31);
    wait_done(cyc, bcyc, seen);
    checks++;
    if (!seen || cyc != 21 || digits !== 24'h000031 || blank !== 6'b111100) begin
      failures++;
      $display("[TB] FAIL conv_after_abort: seen=%b cycles=%0d digits=%h blank=%b expected 1 21 000031 111100", seen, cyc, digits, blank);
    end
  endtask

  task automatic test_start_with_reset();
    int extra;
    @(negedge clk);
    start  = 1'b1;
    bin_in = 20'd77;
    reset  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    reset = 1'b0;
    extra = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra != 0 || digits !== 24'h000000) begin
      failures++;
      $display("[TB] FAIL reset_wins: extra_activity=%0d digits=%h expected 0 000000", extra, digits);
    end
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    start    = 1'b0;
    bin_in   = '0;
    test_reset();
    test_zero();
    test_full_digits();
    test_back_to_back();
    test_overflow();
    test_start_while_busy();
    test_reset_abort();
    test_start_with_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
